mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single off-chip memory port between the I-cache and D-cache miss/write-back interfaces of the 5-stage MIPS core. Each cache issues block-sized read or write transactions through a level handshake; the arbiter grants one requester at a time, with round-robin tie-breaking. It forwards the granted transaction to memory, then returns a one-cycle `ready` pulse and the read data. It sits between the two cache controllers and the memory model/controller, below `IF_stall`/`MEM_stall`.

## Interface
- `ADDR_W`, 28: block address width (word address >> 2).
- `DATA_W`, 128: block data width.

- `clk`  in  1  clock; reset `rst_n`, asynchronous, active-low.
- `rst_n`  in  1  asynchronous active-low reset.
- `ic_read` / `ic_write`  in  1 each  I-cache read/write request (level).
- `ic_addr`  in  ADDR_W  I-cache block address.
- `ic_wdata`  in  DATA_W  I-cache write data.
- `ic_ready`  out  1  I-cache transaction complete (1-cycle pulse).
- `ic_rdata`  out  DATA_W  read data to I-cache.
- `dc_read`, `dc_write`, `dc_addr`, `dc_wdata`, `dc_ready`, `dc_rdata`: D-cache equivalents, same widths and directions.
- `mem_read` / `mem_write`  out  1 each  memory request (registered).
- `mem_addr`  out  ADDR_W  memory block address (registered).
- `mem_wdata`  out  DATA_W  memory write data (registered).
- `mem_ready`  in  1  memory completion (1-cycle pulse).
- `mem_rdata`  in  DATA_W  memory read data, valid when `mem_ready`=1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Requester X is pending when `x_read|x_write`.
  - If only one requester is pending, grant it.
  - If both are pending, grant the one not in `last_grant`.
  - On grant, latch into `mem_*` registers:
    - `mem_addr` = `x_addr`, `mem_wdata` = `x_wdata`.
    - If `x_write`=1: `mem_write`=1 and `mem_read`=0. Write wins over read; read+write together is illegal from a requester.
    - Otherwise `mem_read`=1.
  - Also latch `grant` and `last_grant`, then go to BUSY.
  - With no request, stay in IDLE.
- BUSY: hold all `mem_*` outputs stable.
- BUSY on `mem_ready`=1:
  - Clear `mem_read`/`mem_write`.
  - Pulse `<grant>_ready`=1 for the next cycle.
  - On a read, latch `mem_rdata` into `<grant>_rdata`.
  - Go to DONE.
- DONE:
  - `ready` is high this cycle only.
  - Requests are ignored; the requester deasserts in response to `ready`.
  - Next state is IDLE.
- `x_rdata` holds its last value until the next read completion for that requester. It is never changed by the other requester's transaction.
- Requests are not sampled while in BUSY or DONE. A requester that drops its request mid-BUSY is illegal; the transaction completes anyway.
- `mem_ready` outside BUSY is ignored.
- `last_grant` reset value = D, so the first tie goes to I.
- Reset, at any time including mid-transaction:
  - State returns to IDLE.
  - All outputs go to 0: `mem_read`, `mem_write`, `mem_addr`, `mem_wdata`, `ic_ready`, `dc_ready`, `ic_rdata`, `dc_rdata`.
  - The in-flight transaction is dropped.

## Timing
- Request sampled in IDLE at cycle t → `mem_read`/`mem_write` high at t+1.
- `mem_ready` at cycle t+k (k≥1) → `x_ready`=1 and `x_rdata` valid at t+k+1, with `mem_read`/`mem_write`=0 the same cycle.
- IDLE resumes at t+k+2; a pending request is sampled then, giving `mem_*` high at t+k+3.
- Minimum spacing between back-to-back transactions: 3 cycles overhead plus memory latency.
- Each `ready` is high for exactly 1 cycle per transaction.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Single I read: `ic_read`=1, `ic_addr`=0x0000010; memory returns `mem_ready` after 4 cycles with `mem_rdata`=0x...A5.
  - `mem_read`=1 and `mem_addr`=0x0000010 at t+1.
  - `ic_ready` pulses at t+6 with `ic_rdata`=0x...A5.
  - `dc_ready` stays 0.
- Simultaneous requests from reset: `ic_read` and `dc_write` (`dc_addr`=0x20, `dc_wdata`=0xDEAD) both held.
  - The I transaction is serviced first.
  - The D write follows with `mem_write`=1, `mem_addr`=0x20, `mem_wdata`=0xDEAD.
  - On the next tie, I wins again: `last_grant`=D.
- Continuous contention: both requesters re-request immediately after each `ready` for 8 transactions → grants alternate I, D, I, D…
- `mem_ready` while IDLE, and a second `mem_ready` in DONE → no `ready` pulse and no state change.
- Reset mid-BUSY: assert `rst_n`=0 two cycles after grant.
  - All outputs are 0 immediately (asynchronous).
  - After release, a new `dc_read` is serviced normally.
- `rdata` isolation: I read returns 0x1111, then D read returns 0x2222 → `ic_rdata` stays 0x1111 and `dc_rdata`=0x2222.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide memory port between the I-cache and
// D-cache. One requester is granted at a time (round-robin on ties); the
// granted transaction is forwarded to memory through registered outputs and
// completion is returned as a one-cycle ready pulse plus read data.
//
// state | meaning
// IDLE  | sampling requests, memory port idle
// BUSY  | transaction issued, waiting for mem_ready
// DONE  | ready pulse to the granted requester, requests ignored
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_read,
    input  logic              ic_write,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_wdata,
    output logic              ic_ready,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_nxt;

    // grant / last_grant: 0 = I-cache, 1 = D-cache
    logic              grant, grant_nxt;
    logic              last_grant, last_grant_nxt;
    logic              mem_read_nxt, mem_write_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;
    logic              ic_ready_nxt, dc_ready_nxt;
    logic [DATA_W-1:0] ic_rdata_nxt, dc_rdata_nxt;

    logic ic_pend, dc_pend, any_pend, pick_d;

    // D wins only if I is idle, or on a tie when I was served last
    assign ic_pend  = ic_read | ic_write;
    assign dc_pend  = dc_read | dc_write;
    assign any_pend = ic_pend | dc_pend;
    assign pick_d   = dc_pend & (~ic_pend | ~last_grant);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_pend) state_nxt = BUSY;
            BUSY:    if (mem_ready) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; mem_* hold by default
    always_comb begin
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        mem_read_nxt   = mem_read;
        mem_write_nxt  = mem_write;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        ic_ready_nxt   = 1'b0;
        dc_ready_nxt   = 1'b0;
        ic_rdata_nxt   = ic_rdata;
        dc_rdata_nxt   = dc_rdata;
        case (state)
            IDLE: begin
                if (any_pend) begin
                    grant_nxt      = pick_d;
                    last_grant_nxt = pick_d;
                    mem_addr_nxt   = pick_d ? dc_addr  : ic_addr;
                    mem_wdata_nxt  = pick_d ? dc_wdata : ic_wdata;
                    mem_write_nxt  = pick_d ? dc_write : ic_write;
                    mem_read_nxt   = ~mem_write_nxt;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                    ic_ready_nxt  = ~grant;
                    dc_ready_nxt  = grant;
                    // mem_read is still held here, so it tells us the direction
                    if (mem_read) begin
                        if (grant) dc_rdata_nxt = mem_rdata;
                        else       ic_rdata_nxt = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    // Output and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ic_ready   <= 1'b0;
            dc_ready   <= 1'b0;
            ic_rdata   <= '0;
            dc_rdata   <= '0;
        end else begin
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            mem_read   <= mem_read_nxt;
            mem_write  <= mem_write_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            ic_ready   <= ic_ready_nxt;
            dc_ready   <= dc_ready_nxt;
            ic_rdata   <= ic_rdata_nxt;
            dc_rdata   <= dc_rdata_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized transaction bench for mem_arbiter with a
// transaction-level reference model (who wins, what goes to memory, which
// rdata changes) and a memory responder with random latency.
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ic_read, ic_write, ic_ready;
    logic [ADDR_W-1:0] ic_addr;
    logic [DATA_W-1:0] ic_wdata, ic_rdata;
    logic              dc_read, dc_write, dc_ready;
    logic [ADDR_W-1:0] dc_addr;
    logic [DATA_W-1:0] dc_wdata, dc_rdata;
    logic              mem_read, mem_write, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // requester ops: 0 none, 1 read, 2 write
    int                ic_op, dc_op;
    logic [ADDR_W-1:0] ic_a, dc_a;
    logic [DATA_W-1:0] ic_w, dc_w;
    int                exp_last;   // 0 = I served last, 1 = D
    logic [DATA_W-1:0] exp_ic_rd, exp_dc_rd;
    int                grant_log[$];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_read(ic_read), .ic_write(ic_write), .ic_addr(ic_addr),
        .ic_wdata(ic_wdata), .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        ic_read  = (ic_op == 1);
        ic_write = (ic_op == 2);
        ic_addr  = ic_a;
        ic_wdata = ic_w;
        dc_read  = (dc_op == 1);
        dc_write = (dc_op == 2);
        dc_addr  = dc_a;
        dc_wdata = dc_w;
    endtask

    task automatic new_ic(input int op);
        ic_op = op;
        ic_a  = ADDR_W'($urandom);
        ic_w  = rnd_data();
    endtask

    task automatic new_dc(input int op);
        dc_op = op;
        dc_a  = ADDR_W'($urandom);
        dc_w  = rnd_data();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_read"},  mem_read,  0);
        chk({tag, "_mem_write"}, mem_write, 0);
        chk({tag, "_mem_addr"},  mem_addr,  0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_ic_ready"},  ic_ready,  0);
        chk({tag, "_dc_ready"},  dc_ready,  0);
        chk({tag, "_ic_rdata"},  ic_rdata,  0);
        chk({tag, "_dc_rdata"},  dc_rdata,  0);
    endtask

    // Runs one transaction from IDLE (requests already driven, at least one
    // pending). lat = cycles from issue to mem_ready (>=1).
    task automatic run_txn(input int lat, input bit ready_in_done);
        int                win;
        bit                wr;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ew, rd;
        if (ic_op != 0 && dc_op != 0) win = (exp_last == 0) ? 1 : 0;
        else                          win = (ic_op != 0) ? 0 : 1;
        wr = (win == 0) ? (ic_op == 2) : (dc_op == 2);
        ea = (win == 0) ? ic_a : dc_a;
        ew = (win == 0) ? ic_w : dc_w;
        grant_log.push_back(win);
        step();
        chk("issue_read",  mem_read,  !wr);
        chk("issue_write", mem_write, wr);
        chk("issue_addr",  mem_addr,  ea);
        chk("issue_wdata", mem_wdata, ew);
        exp_last = win;
        for (int i = 1; i < lat; i++) begin
            step();
            chk("busy_hold_rw",   {mem_read, mem_write}, {!wr, wr});
            chk("busy_hold_addr", mem_addr, ea);
            chk("busy_no_ready",  {ic_ready, dc_ready}, 2'b00);
        end
        rd        = rnd_data();
        mem_ready = 1'b1;
        mem_rdata = rd;
        step();
        if (!wr) begin
            if (win == 0) exp_ic_rd = rd;
            else          exp_dc_rd = rd;
        end
        chk("done_ic_ready", ic_ready, win == 0);
        chk("done_dc_ready", dc_ready, win == 1);
        chk("done_rw_clear", {mem_read, mem_write}, 2'b00);
        chk("done_ic_rdata", ic_rdata, exp_ic_rd);
        chk("done_dc_rdata", dc_rdata, exp_dc_rd);
        // requester drops in response to ready; optional stray mem_ready in DONE
        if (win == 0) ic_op = 0;
        else          dc_op = 0;
        drive_reqs();
        mem_ready = ready_in_done;
        mem_rdata = rnd_data();
        step();
        mem_ready = 1'b0;
        chk("idle_no_ready", {ic_ready, dc_ready}, 2'b00);
        chk("idle_rw_clear", {mem_read, mem_write}, 2'b00);
        chk("idle_ic_rdata", ic_rdata, exp_ic_rd);
        chk("idle_dc_rdata", dc_rdata, exp_dc_rd);
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        ic_op = 0; dc_op = 0;
        ic_a = '0; dc_a = '0; ic_w = '0; dc_w = '0;
        drive_reqs();
        exp_last  = 1;
        exp_ic_rd = '0;
        exp_dc_rd = '0;
        #12;
        chk_all_zero("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all_zero("post_reset");

        // single I read, directed address
        ic_op = 1; ic_a = 28'h0000010; ic_w = '0;
        drive_reqs();
        run_txn(5, 0);

        // tie from reset-like state: last was I, so set up I read + D write
        // then check that D wins, then I wins the following tie
        ic_op = 1; ic_a = 28'h0000040;
        dc_op = 2; dc_a = 28'h0000020; dc_w = 128'hDEAD;
        drive_reqs();
        run_txn(2, 0);
        new_dc(2);
        drive_reqs();
        run_txn(3, 0);

        // rdata isolation: I read then D read
        ic_op = 1; ic_a = 28'h100;
        drive_reqs();
        run_txn(1, 0);
        dc_op = 1; dc_a = 28'h200;
        drive_reqs();
        run_txn(2, 1);

        // mem_ready while idle is ignored
        ic_op = 0; dc_op = 0;
        drive_reqs();
        mem_ready = 1'b1;
        mem_rdata = rnd_data();
        step();
        mem_ready = 1'b0;
        chk("idle_mr_ready", {ic_ready, dc_ready}, 2'b00);
        chk("idle_mr_rw",    {mem_read, mem_write}, 2'b00);
        chk("idle_mr_ic_rd", ic_rdata, exp_ic_rd);
        chk("idle_mr_dc_rd", dc_rdata, exp_dc_rd);
        step();
        chk("idle_mr_rw2",   {mem_read, mem_write}, 2'b00);

        // continuous contention: grants must alternate
        grant_log.delete();
        new_ic(int'($urandom_range(1, 2)));
        new_dc(int'($urandom_range(1, 2)));
        drive_reqs();
        for (int t = 0; t < 8; t++) begin
            run_txn(int'($urandom_range(1, 4)), 1'($urandom_range(0, 1)));
            if (ic_op == 0) new_ic(int'($urandom_range(1, 2)));
            if (dc_op == 0) new_dc(int'($urandom_range(1, 2)));
            drive_reqs();
        end
        for (int t = 1; t < 8; t++)
            chk("alternate", 32'(grant_log[t]), 32'(1 - grant_log[t-1]));

        // random traffic
        for (int t = 0; t < 40; t++) begin
            run_txn(int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)));
            if (ic_op == 0) new_ic(int'($urandom_range(0, 2)));
            if (dc_op == 0) new_dc(int'($urandom_range(0, 2)));
            if (ic_op == 0 && dc_op == 0) begin
                if ($urandom_range(0, 1) == 1) new_ic(int'($urandom_range(1, 2)));
                else                           new_dc(int'($urandom_range(1, 2)));
            end
            drive_reqs();
        end

        // reset two cycles after a grant
        step();   // grant edge for whatever is pending
        chk("rst_pre_issue", mem_read | mem_write, 1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_busy_reset");
        ic_op = 0; dc_op = 0;
        drive_reqs();
        exp_last  = 1;
        exp_ic_rd = '0;
        exp_dc_rd = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all_zero("post_reset2");
        new_dc(1);
        drive_reqs();
        run_txn(3, 0);
        // first tie after reset goes to I
        grant_log.delete();
        new_ic(1);
        new_dc(2);
        drive_reqs();
        run_txn(2, 0);
        chk("tie_after_reset", 32'(grant_log[0]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
